// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Purpose
//   Two's-complement adder/subtractor split into STAGES ripple slices.
//   Stage k adds bits [k*SW +: SW] (SW = WIDTH/STAGES) using the carry that
//   stage k-1 registered. The operands travel down the pipeline with the
//   operation so that every stage sees its own slice. The result flags are
//   formed once, at the final stage, from the complete result.
//
// Handshake (both sides use plain valid/ready)
//   A transfer happens on a rising edge where valid && ready are both high.
//   in_ready does not depend on in_valid. out_valid/out/flags do not depend
//   on out_ready. The whole pipeline freezes (stall) while a result is
//   waiting and downstream is not ready, so in_ready = !stall.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      ina/inb/sub carry an operation this cycle
//   in_ready   out  1      operation is accepted this cycle
//   ina        in   WIDTH  operand A
//   inb        in   WIDTH  operand B
//   sub        in   1      0: A+B, 1: A-B
//   out_valid  out  1      out and flags hold a result
//   out_ready  in   1      downstream accepts the result
//   out        out  WIDTH  sum/difference modulo 2^WIDTH
//   carry      out  1      carry out of MSB (sub: 1 = no borrow)
//   overflow   out  1      signed overflow
//   zero       out  1      out == 0
//   negative   out  1      out[WIDTH-1]
// ---------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // -------------------------------------------------------------------------
  // Stage registers. Index k is the register set at the output of stage k.
  // -------------------------------------------------------------------------
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] opa_q,   opa_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_q,   opb_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;

  // Flags exist only at the final stage.
  logic overflow_q, overflow_d;
  logic zero_q,     zero_d;
  logic negative_q, negative_d;

  // What each stage consumes: entry 0 is the input port, entry k is the
  // register set of stage k-1.
  logic [STAGES-1:0]            valid_in;
  logic [STAGES-1:0]            carry_in;
  logic [STAGES-1:0][WIDTH-1:0] opa_in;
  logic [STAGES-1:0][WIDTH-1:0] opb_in;
  logic [STAGES-1:0][WIDTH-1:0] sum_in;

  logic              stall;
  logic [SW:0]       slice_sum;

  // Only the slices still ahead of an operation and the MSBs at the final
  // stage are consumed; the remaining operand bits simply ride along.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{opa_q, opb_q};

  // -------------------------------------------------------------------------
  // Stage inputs. Subtraction is A + ~B + 1: B is inverted here once and the
  // +1 enters as the stage-0 carry-in.
  // -------------------------------------------------------------------------
  always_comb begin
    valid_in    = '0;
    carry_in    = '0;
    opa_in      = '0;
    opb_in      = '0;
    sum_in      = '0;

    valid_in[0] = in_valid;
    carry_in[0] = sub;
    opa_in[0]   = ina;
    opb_in[0]   = sub ? ~inb : inb;
    sum_in[0]   = '0;

    for (int k = 1; k < STAGES; k++) begin
      valid_in[k] = valid_q[k-1];
      carry_in[k] = carry_q[k-1];
      opa_in[k]   = opa_q[k-1];
      opb_in[k]   = opb_q[k-1];
      sum_in[k]   = sum_q[k-1];
    end
  end

  // -------------------------------------------------------------------------
  // Slice adders: stage k fills in result bits [k*SW +: SW] and produces the
  // carry for stage k+1 (or the final carry out of the MSB).
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_in;
    opa_d     = opa_in;
    opb_d     = opb_in;
    sum_d     = sum_in;
    carry_d   = '0;
    slice_sum = '0;

    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, opa_in[k][k*SW +: SW]}
                + {1'b0, opb_in[k][k*SW +: SW]}
                + {{SW{1'b0}}, carry_in[k]};
      sum_d[k][k*SW +: SW] = slice_sum[SW-1:0];
      carry_d[k]           = slice_sum[SW];
    end
  end

  // -------------------------------------------------------------------------
  // Flags from the complete result leaving the last slice adder. opb_d holds
  // the already-inverted B for subtraction, which is what the overflow rule
  // compares against.
  // -------------------------------------------------------------------------
  always_comb begin
    overflow_d = (opa_d[LAST][WIDTH-1] == opb_d[LAST][WIDTH-1]) &&
                 (sum_d[LAST][WIDTH-1] != opa_d[LAST][WIDTH-1]);
    zero_d     = (sum_d[LAST] == '0);
    negative_d = sum_d[LAST][WIDTH-1];
  end

  // -------------------------------------------------------------------------
  // Pipeline registers. Everything advances together when not stalled.
  // Payload registers only load under a valid entry, so bubbles moving
  // through leave the last result (and its flags) visible on the outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      carry_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_d[k]) begin
          carry_q[k] <= carry_d[k];
          opa_q[k]   <= opa_d[k];
          opb_q[k]   <= opb_d[k];
          sum_q[k]   <= sum_d[k];
        end
      end
      if (valid_d[LAST]) begin
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
        negative_q <= negative_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. While rst is high the outputs read as idle/zero even though the
  // registers only clear at the next edge; this keeps an in-flight result
  // from being handed downstream during the reset cycle.
  // -------------------------------------------------------------------------
  assign out_valid = valid_q[LAST] && !rst;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  assign out       = rst ? '0   : sum_q[LAST];
  assign carry     = rst ? 1'b0 : carry_q[LAST];
  assign overflow  = rst ? 1'b0 : overflow_q;
  assign zero      = rst ? 1'b0 : zero_q;
  assign negative  = rst ? 1'b0 : negative_q;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 2: pipeline depth; legal range 1..4; each stage adds one WIDTH/STAGES-bit slice.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  ina/inb/sub valid this cycle.
REQ-006 in_ready  out  1  block accepts the operation this cycle.
REQ-007 ina  in  WIDTH  operand A, two's complement.
REQ-008 inb  in  WIDTH  operand B, two's complement.
REQ-009 sub  in  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  out  1  result and flags valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out  out  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 carry  out  1  carry out of MSB; for sub, 1 = no borrow (A >= B unsigned).
REQ-014 overflow  out  1  signed overflow.
REQ-015 zero  out  1  out == 0.
REQ-016 negative  out  1  out[WIDTH-1].

Function
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-018 Subtraction: operand B bit-inverted, stage-0 carry-in = 1; addition: carry-in = 0.
REQ-019 Stage k adds slice k (bits k*W/S .. (k+1)*W/S-1) plus the carry registered by stage k-1; higher slices travel with the operation in delay registers.
REQ-020 Each stage holds a valid bit; an operation advances one stage per enabled cycle.
REQ-021 Global stall: stall = out_valid && !out_ready; in_ready = !stall; no stage register changes while stall = 1.
REQ-022 Latency: exactly STAGES cycles from input transfer to out_valid with no stall; each stalled cycle adds one.
REQ-023 Throughput: one operation per cycle with out_ready held high; no bubbles are inserted.
REQ-024 Bubbles: in_valid = 0 with stall = 0 loads an invalid entry; bubbles propagate and never raise out_valid.
REQ-025 out and all flags come from the final-stage registers and stay stable while out_valid && !out_ready.
REQ-026 overflow = (A[MSB] == B'[MSB]) && (out[MSB] != A[MSB]), where B' is the inverted B for sub.
REQ-027 Flags are computed only at the final stage, from the complete result.
REQ-028 An operation accepted in the same cycle that a result leaves is legal and not lost.
REQ-029 When out_valid = 0, out and the flags hold their last values; downstream ignores them.
REQ-030 STAGES = 1 degenerates to a registered full-width adder with latency 1.

Reset
REQ-031 rst = 1 at a rising edge clears every stage valid bit, carry, result and flag register to 0.
REQ-032 Outputs while rst is asserted and in the first cycle after: out_valid=0, out=0, carry=0, overflow=0, zero=0, negative=0, in_ready=1.
REQ-033 Reset mid-operation discards all in-flight operations; none appear at the output afterwards.
REQ-034 in_valid is ignored while rst = 1.

Verification
REQ-035 WIDTH=32, STAGES=2: ina=10, inb=5, sub=0, out_ready=1 -> 2 cycles later out=15, carry=0, overflow=0, zero=0, negative=0.
REQ-036 Signed cases, back-to-back: 10+(-5)=5; -10+5=-5 (negative=1); -10+(-5)=-15 (carry=1); 10-10=0 (zero=1, carry=1) -> four results on consecutive cycles, in order.
REQ-037 0xFFFFFFFF+0xFFFFFFFF -> out=0xFFFFFFFE, carry=1, overflow=0, negative=1; 0x7FFFFFFF+1 -> out=0x80000000, overflow=1, carry=0; 0x80000000-1 -> out=0x7FFFFFFF, overflow=1, carry=1.
REQ-038 Backpressure: 3 operations issued, out_ready=0 for 4 cycles -> in_ready=0 while blocked, first result held stable; after release, all 3 results arrive in order with no loss or duplication.
REQ-039 Reset mid-flight: rst pulsed 1 cycle after issuing 2 operations -> out_valid stays 0 and neither result ever appears; the next issued operation returns correctly STAGES cycles later.
REQ-040 Sweep STAGES=1,2,4 and WIDTH=8,32 with random operands against a reference model of the sum and flags -> zero mismatches; latency equals STAGES.
